sa_tile_sequencer: RTL and testbench

//  Hardware tile sequencer for systolic_array_top: walks an M x COUT output over N x N tiles, streams full-depth K operands

---
 rtl/sa_tile_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_sa_tile_sequencer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer: walks an M x COUT output over N x N systolic-array tiles, streams K-deep operands and
// emits masked psum rows. Optional macro SA_SEQ_RELU_EN clamps negative output lanes to +0.0.
module sa_tile_sequencer #(
    parameter int N          = 64,
    parameter int DIM_W      = 16,
    parameter int ADDR_W     = 32,
    parameter int DRAIN_CYC  = 2 * N,
    parameter int STREAM_TMO = 200000,
    localparam int RW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                go,
    input  logic [DIM_W-1:0]    cfg_m,
    input  logic [DIM_W-1:0]    cfg_k,
    input  logic [DIM_W-1:0]    cfg_cout,
    input  logic [ADDR_W-1:0]   cfg_x_base,
    input  logic [ADDR_W-1:0]   cfg_w_base,
    output logic                busy,
    output logic                done,
    output logic                err_tmo,
    output logic [N*ADDR_W-1:0] x_rd_addr,
    input  logic [N*32-1:0]     x_rd_data,
    output logic [N*ADDR_W-1:0] w_rd_addr,
    input  logic [N*32-1:0]     w_rd_data,
    output logic                start_mul,
    input  logic                stall_mul,
    input  logic [N-1:0]        sc_valid_queue,
    output logic [N*32-1:0]     sc_x_data,
    output logic [N*32-1:0]     sc_w_data,
    output logic [RW-1:0]       psum_row_sel,
    input  logic [N*32-1:0]     psum_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIM_W-1:0]    out_m,
    output logic [DIM_W-1:0]    out_c0,
    output logic [N*32-1:0]     out_data,
    output logic [N-1:0]        out_mask
);
    localparam int EW = DIM_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ARM, S_STREAM, S_DRAIN, S_READ, S_NEXT, S_FIN
    } state_t;

    state_t             state_reg, state_next;
    logic [DIM_W-1:0]   m_reg, k_reg, cout_reg;
    logic [ADDR_W-1:0]  xb_reg, wb_reg;
    logic [DIM_W-1:0]   m0_reg, c0_reg;
    logic [RW-1:0]      r_reg;
    logic [31:0]        cnt_reg;
    logic               err_reg;
    logic               ov_reg;
    logic [DIM_W-1:0]   om_reg;
    logic [N*32-1:0]    od_reg;
    logic [N*32-1:0]    row_fix;

    logic               cfg_zero;
    logic [EW-1:0]      row_m;
    logic               row_ok, last_r, read_adv;
    logic [EW-1:0]      c0_nx, m0_nx;
    logic               c_wrap, m_end;
    logic               tmo_hit;

    assign cfg_zero = (cfg_m == '0) || (cfg_k == '0) || (cfg_cout == '0);
    assign row_m    = {1'b0, m0_reg} + EW'(r_reg);
    assign row_ok   = row_m < {1'b0, m_reg};
    assign last_r   = (r_reg == RW'(N - 1));
    // A row is finished either because it lies past M or because its beat was accepted.
    assign read_adv = !row_ok || (ov_reg && out_ready);
    assign c0_nx    = {1'b0, c0_reg} + EW'(N);
    assign m0_nx    = {1'b0, m0_reg} + EW'(N);
    assign c_wrap   = c0_nx >= {1'b0, cout_reg};
    assign m_end    = m0_nx >= {1'b0, m_reg};
    assign tmo_hit  = stall_mul && (cnt_reg == 32'(STREAM_TMO - 1));

    assign busy         = (state_reg != S_IDLE);
    assign done         = (state_reg == S_FIN);
    assign start_mul    = (state_reg == S_START);
    assign err_tmo      = err_reg;
    assign psum_row_sel = r_reg;
    assign out_valid    = ov_reg;
    assign out_m        = om_reg;
    assign out_c0       = c0_reg;
    assign out_data     = od_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [DIM_W-1:0] kx_reg, kw_reg;
            logic [EW-1:0]    lane_m, lane_c;
            logic             x_take, w_take;

            assign lane_m = {1'b0, m0_reg} + EW'(gi);
            assign lane_c = {1'b0, c0_reg} + EW'(gi);
            assign x_take = (state_reg == S_STREAM) && sc_valid_queue[gi] &&
                            (lane_m < {1'b0, m_reg}) && (kx_reg < k_reg);
            assign w_take = (state_reg == S_STREAM) && sc_valid_queue[gi] &&
                            (lane_c < {1'b0, cout_reg}) && (kw_reg < k_reg);

            assign sc_x_data[gi*32 +: 32] = x_take ? x_rd_data[gi*32 +: 32] : 32'h0;
            assign sc_w_data[gi*32 +: 32] = w_take ? w_rd_data[gi*32 +: 32] : 32'h0;
            assign x_rd_addr[gi*ADDR_W +: ADDR_W] = xb_reg + ADDR_W'(lane_m) * ADDR_W'(k_reg) + ADDR_W'(kx_reg);
            assign w_rd_addr[gi*ADDR_W +: ADDR_W] = wb_reg + ADDR_W'(kw_reg) * ADDR_W'(cout_reg) + ADDR_W'(lane_c);
            assign out_mask[gi] = lane_c < {1'b0, cout_reg};

`ifdef SA_SEQ_RELU_EN
            assign row_fix[gi*32 +: 32] = psum_row[gi*32 + 31] ? 32'h0 : psum_row[gi*32 +: 32];
`else
            assign row_fix[gi*32 +: 32] = psum_row[gi*32 +: 32];
`endif

            // Pointers stop advancing at K, so exhausted lanes keep feeding zeros.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    kx_reg <= '0;
                    kw_reg <= '0;
                end else if (state_reg == S_START) begin
                    kx_reg <= '0;
                    kw_reg <= '0;
                end else begin
                    if (x_take) kx_reg <= kx_reg + DIM_W'(1);
                    if (w_take) kw_reg <= kw_reg + DIM_W'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (go) state_next = cfg_zero ? S_FIN : S_START;
            S_START:  state_next = S_ARM;
            S_ARM:    state_next = S_STREAM;
            S_STREAM: begin
                if (!stall_mul)   state_next = S_DRAIN;
                else if (tmo_hit) state_next = S_FIN;
            end
            S_DRAIN:  if (cnt_reg == 32'(DRAIN_CYC - 1)) state_next = S_READ;
            S_READ:   if (read_adv && last_r) state_next = S_NEXT;
            S_NEXT:   state_next = (c_wrap && m_end) ? S_FIN : S_START;
            S_FIN:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= S_IDLE;
            m_reg     <= '0;
            k_reg     <= '0;
            cout_reg  <= '0;
            xb_reg    <= '0;
            wb_reg    <= '0;
            m0_reg    <= '0;
            c0_reg    <= '0;
            r_reg     <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            ov_reg    <= 1'b0;
            om_reg    <= '0;
            od_reg    <= '0;
        end else begin
            state_reg <= state_next;
            // Counter restarts on every state change; STREAM and DRAIN use it as their dwell time.
            cnt_reg   <= (state_next != state_reg) ? 32'd0 : cnt_reg + 32'd1;
            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        m_reg    <= cfg_m;
                        k_reg    <= cfg_k;
                        cout_reg <= cfg_cout;
                        xb_reg   <= cfg_x_base;
                        wb_reg   <= cfg_w_base;
                        m0_reg   <= '0;
                        c0_reg   <= '0;
                        err_reg  <= 1'b0;
                    end
                end
                S_STREAM: if (tmo_hit) err_reg <= 1'b1;
                S_DRAIN:  r_reg <= '0;
                S_READ: begin
                    if (row_ok && !ov_reg) begin
                        ov_reg <= 1'b1;
                        od_reg <= row_fix;
                        om_reg <= row_m[DIM_W-1:0];
                    end else if (ov_reg && out_ready) begin
                        ov_reg <= 1'b0;
                    end
                    if (read_adv) r_reg <= last_r ? '0 : r_reg + RW'(1);
                end
                S_NEXT: begin
                    if (c_wrap) begin
                        c0_reg <= '0;
                        m0_reg <= m0_nx[DIM_W-1:0];
                    end else begin
                        c0_reg <= c0_nx[DIM_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_tile_sequencer.sv
// tb_sa_tile_sequencer: N=4 bench with a scratchpad, an operand-collecting array model and a
// reference built directly from memory contents (integer dot products stand in for fp32 math).
`timescale 1ns/1ps
module tb_sa_tile_sequencer;
    localparam int N      = 4;
    localparam int DIM_W  = 16;
    localparam int ADDR_W = 32;
    localparam int TMO    = 100;

    logic                clk = 1'b0;
    logic                n_rst;
    logic                go;
    logic [DIM_W-1:0]    cfg_m, cfg_k, cfg_cout;
    logic [ADDR_W-1:0]   cfg_x_base, cfg_w_base;
    logic                busy, done, err_tmo;
    logic [N*ADDR_W-1:0] x_rd_addr, w_rd_addr;
    logic [N*32-1:0]     x_rd_data, w_rd_data;
    logic                start_mul, stall_mul;
    logic [N-1:0]        sc_valid_queue;
    logic [N*32-1:0]     sc_x_data, sc_w_data;
    logic [$clog2(N)-1:0] psum_row_sel;
    logic [N*32-1:0]     psum_row;
    logic                out_valid, out_ready;
    logic [DIM_W-1:0]    out_m, out_c0;
    logic [N*32-1:0]     out_data;
    logic [N-1:0]        out_mask;

    always #5 clk = ~clk;

    sa_tile_sequencer #(.N(N), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .STREAM_TMO(TMO)) dut (
        .clk(clk), .n_rst(n_rst), .go(go),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_cout(cfg_cout),
        .cfg_x_base(cfg_x_base), .cfg_w_base(cfg_w_base),
        .busy(busy), .done(done), .err_tmo(err_tmo),
        .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
        .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .start_mul(start_mul), .stall_mul(stall_mul), .sc_valid_queue(sc_valid_queue),
        .sc_x_data(sc_x_data), .sc_w_data(sc_w_data),
        .psum_row_sel(psum_row_sel), .psum_row(psum_row),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_m(out_m), .out_c0(out_c0), .out_data(out_data), .out_mask(out_mask)
    );

    typedef struct {
        logic [DIM_W-1:0] m;
        logic [DIM_W-1:0] c0;
        logic [N-1:0]     mask;
        logic [N*32-1:0]  data;
    } row_t;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] mem [1024];
    logic [31:0] psum_mem [N][N];
    logic [31:0] xs [N][16];
    logic [31:0] ws [N][16];
    int          cnt [N];
    bit          hang_mode = 1'b0;
    bit          relu_mode = 1'b0;
    int          job_k = 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            x_rd_data[i*32 +: 32] = mem[x_rd_addr[i*ADDR_W +: 10]];
            w_rd_data[i*32 +: 32] = mem[w_rd_addr[i*ADDR_W +: 10]];
            psum_row[i*32 +: 32]  = psum_mem[psum_row_sel][i];
        end
    end

    // Array model: raise stall on start_mul, collect K+1 operands per lane at random cycles, then
    // produce psum[r][c] = sum_j x_r[j] * w_c[j].
    initial begin : array_model
        bit          running;
        bit          aborted;
        bit          all_done;
        logic [31:0] s;
        stall_mul      = 1'b0;
        sc_valid_queue = '0;
        forever begin
            @(negedge clk);
            if (n_rst && start_mul) begin
                for (int i = 0; i < N; i++) cnt[i] = 0;
                stall_mul = 1'b1;
                @(negedge clk);
                if (hang_mode) begin
                    for (int t = 0; t < 1000 && n_rst && busy; t++) @(negedge clk);
                end else begin
                    running = 1'b1;
                    aborted = 1'b0;
                    while (running) begin
                        @(negedge clk);
                        all_done = 1'b1;
                        for (int i = 0; i < N; i++) if (cnt[i] <= job_k) all_done = 1'b0;
                        if (!n_rst) begin
                            aborted = 1'b1;
                            running = 1'b0;
                        end else if (all_done) begin
                            running = 1'b0;
                        end else begin
                            for (int i = 0; i < N; i++)
                                sc_valid_queue[i] = (cnt[i] <= job_k) && ($urandom_range(0, 2) != 0);
                            #1;
                            for (int i = 0; i < N; i++) begin
                                if (sc_valid_queue[i]) begin
                                    xs[i][cnt[i]] = sc_x_data[i*32 +: 32];
                                    ws[i][cnt[i]] = sc_w_data[i*32 +: 32];
                                    cnt[i]++;
                                end
                            end
                        end
                    end
                    sc_valid_queue = '0;
                    if (!aborted) begin
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                s = '0;
                                for (int j = 0; j <= job_k; j++) s = s + xs[r][j] * ws[c][j];
                                if (relu_mode) psum_mem[r][c] = (c % 2 == 0) ? 32'hBF800000 : 32'h3F800000;
                                else           psum_mem[r][c] = s;
                            end
                        end
                    end
                end
                stall_mul = 1'b0;
            end
        end
    end

    function automatic logic [31:0] relu_ref(input logic [31:0] v);
`ifdef SA_SEQ_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [31:0] ref_dot(input int m, input int c, input int k, input int cout,
                                            input logic [31:0] xb, input logic [31:0] wb);
        logic [31:0] s, xa, wa;
        s = '0;
        for (int kk = 0; kk < k; kk++) begin
            xa = xb + 32'(m * k + kk);
            wa = wb + 32'(kk * cout + c);
            s  = s + mem[xa[9:0]] * mem[wa[9:0]];
        end
        return s;
    endfunction

    task automatic run_job(input string name, input int m, input int k, input int cout,
                           input logic [31:0] xb, input logic [31:0] wb, input int mode, input bit poke);
        row_t             exp_q[$];
        row_t             e;
        int               cyc, starts, tiles, hold_left;
        bit               done_seen, held, first_hs;
        logic [N*32-1:0]  h_data;
        logic [DIM_W-1:0] h_m;
        logic [31:0]      v;
        // Reference walk: row tiles outer, channel tiles inner, rows past M never emitted.
        for (int mt = 0; mt < m; mt += N) begin
            for (int ct = 0; ct < cout; ct += N) begin
                for (int r = 0; r < N; r++) begin
                    if (mt + r < m) begin
                        e.m  = DIM_W'(mt + r);
                        e.c0 = DIM_W'(ct);
                        for (int i = 0; i < N; i++) begin
                            e.mask[i] = (ct + i < cout);
                            if (relu_mode)         v = (i % 2 == 0) ? 32'hBF800000 : 32'h3F800000;
                            else if (ct + i < cout) v = ref_dot(mt + r, ct + i, k, cout, xb, wb);
                            else                    v = 32'h0;
                            e.data[i*32 +: 32] = relu_ref(v);
                        end
                        exp_q.push_back(e);
                    end
                end
            end
        end
        tiles = ((m + N - 1) / N) * ((cout + N - 1) / N);
        job_k = k;
        @(negedge clk);
        cfg_m = DIM_W'(m); cfg_k = DIM_W'(k); cfg_cout = DIM_W'(cout);
        cfg_x_base = xb; cfg_w_base = wb;
        go = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checks++;
        if (busy !== 1'b1 || err_tmo !== 1'b0)
            $display("FAIL %s accept: busy=%b err_tmo=%b want busy=1 err_tmo=0", name, busy, err_tmo);
        else passes++;

        cyc = 0; starts = 0; hold_left = 0; done_seen = 0; held = 0; first_hs = 0;
        h_data = '0; h_m = '0;
        while (!done_seen && cyc < 4000) begin
            starts += int'(start_mul);
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== h_data || out_m !== h_m)
                    $display("FAIL %s hold_stable: valid=%b m=%0d data=%h want valid=1 m=%0d data=%h",
                             name, out_valid, out_m, out_data, h_m, h_data);
                else passes++;
            end
            if (done) begin
                done_seen = 1'b1;
            end else begin
                if (poke && cyc == 3) begin
                    go = 1'b1; cfg_m = 16'd1; cfg_k = 16'd1; cfg_cout = 16'd1;
                end else begin
                    go = 1'b0;
                end
                case (mode)
                    0: out_ready = 1'b1;
                    1: out_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (hold_left > 0) begin
                            out_ready = 1'b0;
                            hold_left--;
                        end else out_ready = 1'b1;
                    end
                endcase
                if (out_valid && out_ready) begin
                    $display("%s row m=%0d c0=%0d mask=%b data=%h", name, out_m, out_c0, out_mask, out_data);
                    checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL %s extra_row: got m=%0d want no row", name, out_m);
                    end else begin
                        passes++;
                        e = exp_q.pop_front();
                        checks++;
                        if (out_m !== e.m) $display("FAIL %s row_m: got %0d want %0d", name, out_m, e.m);
                        else passes++;
                        checks++;
                        if (out_c0 !== e.c0 || out_mask !== e.mask)
                            $display("FAIL %s row_c0_mask: got c0=%0d mask=%b want c0=%0d mask=%b",
                                     name, out_c0, out_mask, e.c0, e.mask);
                        else passes++;
                        checks++;
                        if (out_data !== e.data)
                            $display("FAIL %s row_data m=%0d: got %h want %h", name, out_m, out_data, e.data);
                        else passes++;
                    end
                    if (mode == 2 && !first_hs) hold_left = 10;
                    first_hs = 1'b1;
                end
                held   = out_valid && !out_ready;
                h_data = out_data;
                h_m    = out_m;
                @(negedge clk);
                cyc++;
            end
        end
        go = 1'b0;
        checks++;
        if (!done_seen) $display("FAIL %s done_timeout: got no done in %0d cycles want done", name, cyc);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL %s rows_missing: got %0d left want 0", name, exp_q.size());
        else passes++;
        checks++;
        if (starts != tiles) $display("FAIL %s tile_count: got %0d want %0d", name, starts, tiles);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_tmo !== 1'b0)
            $display("FAIL %s post_done: busy=%b done=%b err=%b want 0 0 0", name, busy, done, err_tmo);
        else passes++;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) mem[i] = $urandom_range(0, 1000);
    endtask

    task automatic test_reset();
        n_rst = 1'b0; go = 1'b0; out_ready = 1'b0;
        cfg_m = '0; cfg_k = '0; cfg_cout = '0; cfg_x_base = '0; cfg_w_base = '0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) psum_mem[r][c] = '0;
        fill_random();
        #12;
        checks++;
        if ({busy, done, err_tmo, start_mul, out_valid} !== 5'b0)
            $display("FAIL reset_ctrl: got busy/done/err/start/valid=%b want 00000",
                     {busy, done, err_tmo, start_mul, out_valid});
        else passes++;
        checks++;
        if (sc_x_data !== '0 || sc_w_data !== '0 || out_m !== '0 || out_c0 !== '0 || out_data !== '0)
            $display("FAIL reset_data: got x=%h w=%h m=%0d c0=%0d data=%h want all 0",
                     sc_x_data, sc_w_data, out_m, out_c0, out_data);
        else passes++;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_identity();
        fill_random();
        for (int m = 0; m < 4; m++) for (int k = 0; k < 4; k++) mem[m*4 + k] = 32'(m + k);
        for (int k = 0; k < 4; k++) for (int c = 0; c < 4; c++) mem[100 + k*4 + c] = (k == c) ? 32'd1 : 32'd0;
        run_job("identity", 4, 4, 4, 32'd0, 32'd100, 0, 1'b0);
    endtask

    task automatic test_multi_tile();
        fill_random();
        run_job("multi_tile", 6, 3, 5, 32'd40, 32'd300, 1, 1'b1);
    endtask

    task automatic test_back_pressure();
        fill_random();
        run_job("back_pressure", 4, 2, 3, 32'd7, 32'd500, 2, 1'b0);
    endtask

    task automatic test_zero_dim();
        for (int z = 0; z < 3; z++) begin
            @(negedge clk);
            cfg_m = (z == 0) ? 16'd0 : 16'd3;
            cfg_k = (z == 1) ? 16'd0 : 16'd2;
            cfg_cout = (z == 2) ? 16'd0 : 16'd2;
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            checks++;
            if (done !== 1'b1 || busy !== 1'b1 || start_mul !== 1'b0)
                $display("FAIL zero_dim%0d fin: done=%b busy=%b start=%b want 1 1 0", z, done, busy, start_mul);
            else passes++;
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
                $display("FAIL zero_dim%0d idle: done=%b busy=%b valid=%b want 0 0 0", z, done, busy, out_valid);
            else passes++;
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit saw_valid;
        fill_random();
        hang_mode = 1'b1;
        job_k = 4;
        @(negedge clk);
        cfg_m = 16'd4; cfg_k = 16'd4; cfg_cout = 16'd4; cfg_x_base = '0; cfg_w_base = 32'd64;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cyc = 0; saw_valid = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid) saw_valid = 1'b1;
        end
        checks++;
        if (done !== 1'b1 || cyc < TMO || cyc > TMO + 4)
            $display("FAIL timeout_done: got done=%b after %0d cycles want done near %0d", done, cyc, TMO + 2);
        else passes++;
        checks++;
        if (err_tmo !== 1'b1 || saw_valid)
            $display("FAIL timeout_err: got err_tmo=%b rows=%b want err_tmo=1 rows=0", err_tmo, saw_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err_tmo !== 1'b1)
            $display("FAIL timeout_sticky: got busy=%b err_tmo=%b want 0 1", busy, err_tmo);
        else passes++;
        hang_mode = 1'b0;
        run_job("after_timeout", 3, 2, 2, 32'd11, 32'd200, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int w;
        fill_random();
        job_k = 5;
        @(negedge clk);
        cfg_m = 16'd5; cfg_k = 16'd5; cfg_cout = 16'd6; cfg_x_base = 32'd3; cfg_w_base = 32'd400;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        w = 0;
        while (!stall_mul && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (stall_mul !== 1'b1) $display("FAIL reset_mid_stream: got stall=%b want 1", stall_mul);
        else passes++;
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, err_tmo, start_mul, out_valid} !== 5'b0 || sc_x_data !== '0 || sc_w_data !== '0)
            $display("FAIL reset_mid_outputs: got ctrl=%b x=%h w=%h want all 0",
                     {busy, done, err_tmo, start_mul, out_valid}, sc_x_data, sc_w_data);
        else passes++;
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        fill_random();
        run_job("after_reset", 5, 3, 6, 32'd21, 32'd600, 1, 1'b0);
    endtask

    task automatic test_relu();
        fill_random();
        relu_mode = 1'b1;
        run_job("relu", 2, 2, 4, 32'd0, 32'd50, 0, 1'b0);
        relu_mode = 1'b0;
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 4; j++) begin
            fill_random();
            run_job("random", int'($urandom_range(1, 9)), int'($urandom_range(1, 8)), int'($urandom_range(1, 9)),
                    32'($urandom_range(0, 300)), 32'($urandom_range(300, 700)), 1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_multi_tile();
        test_back_pressure();
        test_zero_dim();
        test_timeout();
        test_reset_mid();
        test_relu();
        test_random_jobs();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
